// File: rtl/mc_controller_hs.sv
// mc_controller_hs: multi-cycle CPU control FSM with a ready/valid memory
// handshake and a saturating wait-state timeout (bus_err on expiry).
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to trap unlisted opcodes,
// unlisted R-type functs and data-memory timeouts into S_TRAP.
module mc_controller_hs #(
  parameter int ALUOP_W     = 4,
  parameter int WAIT_W      = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               ExtOp,
  output logic               LuiOp,
  output logic [2:0]         MemtoReg,
  output logic [1:0]         RegDst,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSource,
  output logic               bus_err,
  output logic               exc,
  output logic               instr_done
);

  localparam logic [ALUOP_W-1:0] AOP_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AOP_BEQ   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AOP_RTYPE = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AOP_ADDIU = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] AOP_ANDI  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] AOP_SLTI  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] AOP_SLTIU = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] AOP_BNE   = ALUOP_W'(7);
  localparam logic [WAIT_W-1:0]  TIMEOUT   = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_RST,
    S_IF,
    S_ID,
    S_EX,
`ifdef CTRL_ILLEGAL_TRAP_EN
    S_MEM,
    S_TRAP
`else
    S_MEM
`endif
  } state_t;

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              rst_done;
  logic              waiting;
  logic              timeout_hit;

  assign waiting     = (state == S_IF) || (state == S_MEM);
  assign timeout_hit = waiting && (MEM_TIMEOUT != 0) && (wait_cnt == TIMEOUT) && !mem_ready;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic funct_known;
  // R-type functs the datapath implements; anything else traps
  always_comb begin
    case (Funct)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2a, 6'h2b: funct_known = 1'b1;
      default:      funct_known = 1'b0;
    endcase
  end
`endif

  // State, reset-release flag and saturating wait counter.
  // rst_done holds S_RST for one edge after release so the first fetch
  // lands on the second rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_RST;
      wait_cnt <= '0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      state    <= next_state;
      if ((next_state != state) || timeout_hit)
        wait_cnt <= '0;
      else if (waiting && !mem_ready && (wait_cnt != TIMEOUT))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Control decode and next-state selection
  always_comb begin
    next_state  = state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ExtOp       = 1'b0;
    LuiOp       = 1'b0;
    MemtoReg    = 3'b000;
    RegDst      = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = AOP_ADD;
    PCSource    = 2'b00;
    bus_err     = 1'b0;
    exc         = 1'b0;
    instr_done  = 1'b0;
    case (state)
      S_RST: begin
        if (rst_done) next_state = S_IF;
      end
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = S_ID;
        end else if (timeout_hit) begin
          bus_err    = 1'b1;
          next_state = S_IF;
        end
      end
      S_ID: begin
        ALUSrcB    = 2'b11;
        ExtOp      = 1'b1;
        next_state = S_EX;
      end
      S_EX: begin
        next_state = S_IF;
        instr_done = 1'b1;
        case (OpCode)
          6'h00: begin
            ALUSrcA = ((Funct == 6'h00) || (Funct == 6'h02) || (Funct == 6'h03)) ? 2'b10 : 2'b01;
            if (Funct == 6'h08) begin
              PCWrite = 1'b1;
            end else if (Funct == 6'h09) begin
              PCWrite  = 1'b1;
              RegWrite = 1'b1;
              RegDst   = 2'b01;
              MemtoReg = 3'b010;
            end else begin
              RegWrite = 1'b1;
              RegDst   = 2'b01;
              MemtoReg = 3'b011;
              ALUOp    = AOP_RTYPE;
`ifdef CTRL_ILLEGAL_TRAP_EN
              if (!funct_known) begin
                RegWrite   = 1'b0;
                instr_done = 1'b0;
                next_state = S_TRAP;
              end
`endif
            end
          end
          6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f: begin
            ALUSrcA  = 2'b01;
            ALUSrcB  = 2'b10;
            ExtOp    = (OpCode != 6'h0c);
            LuiOp    = (OpCode == 6'h0f);
            RegWrite = 1'b1;
            MemtoReg = 3'b011;
            case (OpCode)
              6'h09:   ALUOp = AOP_ADDIU;
              6'h0a:   ALUOp = AOP_SLTI;
              6'h0b:   ALUOp = AOP_SLTIU;
              6'h0c:   ALUOp = AOP_ANDI;
              default: ALUOp = AOP_ADD;
            endcase
          end
          6'h23, 6'h2b: begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            ExtOp      = 1'b1;
            instr_done = 1'b0;
            next_state = S_MEM;
          end
          6'h04, 6'h05: begin
            PCWriteCond = 1'b1;
            ALUSrcA     = 2'b01;
            PCSource    = 2'b01;
            ALUOp       = (OpCode == 6'h04) ? AOP_BEQ : AOP_BNE;
          end
          6'h02, 6'h03: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            if (OpCode == 6'h03) begin
              RegWrite = 1'b1;
              RegDst   = 2'b10;
              MemtoReg = 3'b010;
            end
          end
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            instr_done = 1'b0;
            next_state = S_TRAP;
`endif
          end
        endcase
      end
      S_MEM: begin
        IorD     = 1'b1;
        MemRead  = (OpCode == 6'h23);
        MemWrite = (OpCode != 6'h23);
        if (mem_ready) begin
          instr_done = 1'b1;
          next_state = S_IF;
          if (OpCode == 6'h23) begin
            RegWrite = 1'b1;
            MemtoReg = 3'b100;
          end
        end else if (timeout_hit) begin
          bus_err  = 1'b1;
          MemWrite = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
          next_state = S_TRAP;
`else
          next_state = S_IF;
`endif
        end
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b11;
        exc        = 1'b1;
        instr_done = 1'b1;
        next_state = S_IF;
      end
`endif
      default: next_state = S_RST;
    endcase
  end

endmodule
